rgbled_ctrl: RTL and testbench
==============================

Name: rgbled_ctrl

Overview:
- Frame sequencer that sits directly upstream of the ws281x_drv instance and feeds it per-LED colour words.
- Holds a colour per LED for the daisy-chained WS2812 RGB LEDs and streams them over the driver's data_valid/data_ack handshake, marking the last word.
- Inserts the mandatory latch gap after each frame, then refreshes periodically or on request.
- Runs in the main_clk_buf domain. Replaces the constant "all off" stimulus currently fed to the driver.

Parameters:
- NumLeds, 2: LEDs in the chain; legal range 1..16.
- ClkFreq, 25_000_000: main_clk_buf frequency in Hz.
- LatchUs, 80: minimum low time after a frame, in microseconds.
- RefreshCycles, 250_000: cycles between frame starts when idle (10 ms at 25 MHz).

Ports:
- main_clk_buf  in  1  clock
- rst_sys_n  in  1  reset
- led_rgb_i  in  NumLeds*24  colour per LED; LED k at bits [24k+23:24k], ordered {r,g,b}; LED 0 is nearest the FPGA
- update_i  in  1  single-cycle request to send a new frame
- off_i  in  1  level; when high, a frame start captures all-zero colours
- busy_o  out  1  high from frame start until the latch gap ends
- go_o  out  1  to driver go_i
- drv_idle_i  in  1  from driver idle_o
- data_o  out  24  to driver data_i, ordered {g,r,b}
- data_valid_o  out  1  to driver data_valid_i
- data_last_o  out  1  to driver data_last_i
- data_ack_i  in  1  from driver data_ack_o
- Interface rule: reset rst_sys_n, asynchronous, active-low; clock main_clk_buf.

Behaviour:
- Reset values: busy_o=0, go_o=0, data_o=0, data_valid_o=0, data_last_o=0. Internal state: FSM=IDLE, refresh counter=0, pending=1, so the first frame starts after reset.
- Constant LatchCycles = ceil(ClkFreq*LatchUs/1e6) = 2000 at the defaults.
- FSM states: IDLE, LOAD, SEND, DRAIN, LATCH.
- IDLE -> LOAD when pending=1 or the refresh counter reaches RefreshCycles-1.
  - In LOAD, the refresh counter clears and pending clears.
- LOAD (1 cycle):
  - Snapshot led_rgb_i into the shadow array; if off_i=1, snapshot zeros instead.
  - Set index=0 and busy_o=1.
- SEND:
  - go_o=1, data_valid_o=1.
  - data_o = shadow[index] reordered to {g,r,b}.
  - data_last_o = (index==NumLeds-1).
- Handshake:
  - data_o and data_last_o stay stable while data_valid_o=1 and no ack has arrived.
  - On data_ack_i: if last, go to DRAIN; otherwise increment index and present the next word the following cycle.
  - data_valid_o stays high between words.
- DRAIN:
  - data_valid_o=0, go_o=0.
  - Wait for drv_idle_i=1, then go to LATCH.
- LATCH:
  - Count LatchCycles with data_valid_o=0.
  - On completion go to IDLE, busy_o=0.
- update_i is accepted in any state and sets pending. A request during LOAD..LATCH produces exactly one further frame, after LATCH; multiple requests collapse into one.
- The refresh counter runs only in IDLE and saturates. A refresh coinciding with update_i produces a single frame.
- data_ack_i outside SEND is ignored.
- led_rgb_i changes mid-frame do not affect the frame in flight.
- Reset asserted mid-frame: all outputs return to reset values asynchronously; the driver shares the same reset.

Optional Feature:
- Macro: RGBLED_BRIGHTNESS_EN.
- Enabled:
  - Adds input brightness_i [7:0].
  - Each channel is scaled to (c*(brightness_i+1))>>8 when the snapshot is taken in LOAD.
  - brightness_i=255 gives identity; brightness_i=0 gives c>>8 = 0.
- Disabled: no port, no multiplier; colours pass unscaled.

Decomposition:
- Package rgbled_pkg holds:
  - typedef rgb_t, a packed struct {r,g,b} of 8-bit fields;
  - the state enum rgbled_state_e;
  - the function to_grb().
- LatchCycles is a localparam of rgbled_ctrl.
- Optional sub-module rgbled_scale: a 3-channel 8x9 multiply with shift, instantiated only under RGBLED_BRIGHTNESS_EN.

Test Plan:
- Release reset with NumLeds=2, led_rgb_i={24'h0000FF, 24'h112233} (LED 1, LED 0), driver model acks 3 cycles after each valid.
  - Expect data_o=24'h221133 with last=0, then data_o=24'h0000FF with last=1.
  - Then busy_o stays high for ≥2000 cycles after drv_idle_i rises.
- Hold data_ack_i low for 50 cycles during SEND and change led_rgb_i meanwhile → data_o, data_last_o and data_valid_o are held unchanged.
- Pulse update_i three times during LATCH → exactly one additional frame, starting the cycle after LATCH ends.
- Set off_i=1 with a non-zero led_rgb_i, then pulse update_i → both words are 24'h000000.
- Set update_i=0 and wait → frame starts are spaced exactly RefreshCycles + frame time, checked over 3 frames.
- Assert rst_sys_n low mid-word → all outputs 0 immediately; after release, a full frame is sent. Under RGBLED_BRIGHTNESS_EN, brightness_i=127 with r=8'hFF gives r=8'h7F.

Source files
------------

// File: rtl/rgbled_pkg.sv
// Shared types for the WS2812 frame sequencer: colour struct, FSM encoding and
// the wire-order helper used when presenting words to ws281x_drv.
package rgbled_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef logic [2:0] rgbled_state_e;

  localparam rgbled_state_e StIdle  = 3'd0;
  localparam rgbled_state_e StLoad  = 3'd1;
  localparam rgbled_state_e StSend  = 3'd2;
  localparam rgbled_state_e StDrain = 3'd3;
  localparam rgbled_state_e StLatch = 3'd4;

  // WS2812 parts shift green first.
  function automatic logic [23:0] to_grb(rgb_t c);
    return {c.g, c.r, c.b};
  endfunction

endpackage

// File: rtl/rgbled_scale.sv
// Per-channel brightness scaling, c * (brightness + 1) >> 8. Only instantiated
// when RGBLED_BRIGHTNESS_EN is defined.
module rgbled_scale
  import rgbled_pkg::*;
(
  input  rgb_t       c_i,
  input  logic [7:0] brightness_i,
  output rgb_t       c_o
);

  logic [8:0] gain;
  assign gain = {1'b0, brightness_i} + 9'd1;

  // 255 * 256 still fits in 16 bits, so the top byte is the scaled value.
  function automatic logic [7:0] scale(logic [7:0] c, logic [8:0] k);
    logic [15:0] p;
    p = 16'(c) * 16'(k);
    return p[15:8];
  endfunction

  assign c_o.r = scale(c_i.r, gain);
  assign c_o.g = scale(c_i.g, gain);
  assign c_o.b = scale(c_i.b, gain);

endmodule

// File: rtl/rgbled_ctrl.sv
// WS2812 frame sequencer feeding ws281x_drv: snapshots per-LED colours, streams them,
// then holds the latch gap. Define RGBLED_BRIGHTNESS_EN to add brightness_i scaling.
module rgbled_ctrl
  import rgbled_pkg::*;
#(
  parameter int unsigned NumLeds       = 2,
  parameter int unsigned ClkFreq       = 25_000_000,
  parameter int unsigned LatchUs       = 80,
  parameter int unsigned RefreshCycles = 250_000
) (
  input  logic                 main_clk_buf,
  input  logic                 rst_sys_n,
  input  logic [NumLeds*24-1:0] led_rgb_i,
  input  logic                 update_i,
  input  logic                 off_i,
`ifdef RGBLED_BRIGHTNESS_EN
  input  logic [7:0]           brightness_i,
`endif
  output logic                 busy_o,
  output logic                 go_o,
  input  logic                 drv_idle_i,
  output logic [23:0]          data_o,
  output logic                 data_valid_o,
  output logic                 data_last_o,
  input  logic                 data_ack_i
);

  localparam int unsigned LatchCycles =
      32'((64'(ClkFreq) * 64'(LatchUs) + 64'd999_999) / 64'd1_000_000);
  localparam int unsigned IdxW = (NumLeds > 1) ? $clog2(NumLeds) : 1;
  localparam int unsigned RefW = $clog2(RefreshCycles + 1);
  localparam int unsigned LatW = $clog2(LatchCycles + 1);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLeds - 1);
  localparam logic [RefW-1:0] RefTop  = RefW'(RefreshCycles - 1);
  localparam logic [LatW-1:0] LatTop  = LatW'(LatchCycles - 1);

  rgbled_state_e   state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [RefW-1:0] refresh_q, refresh_d;
  logic [LatW-1:0] latch_q, latch_d;
  logic            pending_q, pending_d;
  logic            load_en;
  logic            in_send;

  rgb_t shadow_q [NumLeds];
  rgb_t snap     [NumLeds];

  for (genvar k = 0; k < NumLeds; k++) begin : g_led
    rgb_t raw;
    assign raw = off_i ? '0 : rgb_t'(led_rgb_i[24*k +: 24]);
`ifdef RGBLED_BRIGHTNESS_EN
    rgbled_scale u_scale (
      .c_i          (raw),
      .brightness_i (brightness_i),
      .c_o          (snap[k])
    );
`else
    assign snap[k] = raw;
`endif
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    refresh_d = refresh_q;
    latch_d   = latch_q;
    pending_d = pending_q | update_i;
    load_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (refresh_q != RefTop) refresh_d = refresh_q + 1'b1;
        if (pending_q || refresh_q == RefTop) state_d = StLoad;
      end
      StLoad: begin
        // A request landing in this very cycle still earns a follow-up frame.
        pending_d = update_i;
        refresh_d = '0;
        load_en   = 1'b1;
        idx_d     = '0;
        state_d   = StSend;
      end
      StSend: begin
        if (data_ack_i) begin
          if (idx_q == LastIdx) state_d = StDrain;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      StDrain: begin
        if (drv_idle_i) begin
          latch_d = '0;
          state_d = StLatch;
        end
      end
      StLatch: begin
        if (latch_q == LatTop) state_d = StIdle;
        else                   latch_d = latch_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      refresh_q <= '0;
      latch_q   <= '0;
      pending_q <= 1'b1;
      for (int k = 0; k < NumLeds; k++) shadow_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      refresh_q <= refresh_d;
      latch_q   <= latch_d;
      pending_q <= pending_d;
      if (load_en) begin
        for (int k = 0; k < NumLeds; k++) shadow_q[k] <= snap[k];
      end
    end
  end

  assign in_send      = (state_q == StSend);
  assign busy_o       = (state_q != StIdle);
  assign go_o         = in_send;
  assign data_valid_o = in_send;
  assign data_last_o  = in_send && (idx_q == LastIdx);
  assign data_o       = in_send ? to_grb(shadow_q[idx_q]) : 24'h0;

endmodule

// File: tb/tb_rgbled_ctrl.sv
// Directed bench for rgbled_ctrl with a simple ws281x_drv handshake model
// (ack three cycles into each word, idle five cycles after the last word).
module tb_rgbled_ctrl;

  localparam int unsigned NumLeds       = 2;
  localparam int unsigned RefreshCycles = 500;
  localparam int unsigned LatchCycles   = 2000;
  // LOAD + 4 cycles per word + 6 cycles of DRAIN with this driver model + latch gap.
  localparam int unsigned FrameCycles   = 1 + NumLeds * 4 + 6 + LatchCycles;

  logic                  main_clk_buf = 1'b0;
  logic                  rst_sys_n;
  logic [NumLeds*24-1:0] led_rgb;
  logic                  update;
  logic                  off;
  logic                  busy, go, drv_idle, data_valid, data_last, data_ack;
  logic [23:0]           data;
`ifdef RGBLED_BRIGHTNESS_EN
  logic [7:0]            brightness;
`endif

  rgbled_ctrl #(
    .NumLeds       (NumLeds),
    .ClkFreq       (25_000_000),
    .LatchUs       (80),
    .RefreshCycles (RefreshCycles)
  ) dut (
    .main_clk_buf (main_clk_buf),
    .rst_sys_n    (rst_sys_n),
    .led_rgb_i    (led_rgb),
    .update_i     (update),
    .off_i        (off),
`ifdef RGBLED_BRIGHTNESS_EN
    .brightness_i (brightness),
`endif
    .busy_o       (busy),
    .go_o         (go),
    .drv_idle_i   (drv_idle),
    .data_o       (data),
    .data_valid_o (data_valid),
    .data_last_o  (data_last),
    .data_ack_i   (data_ack)
  );

  always #5 main_clk_buf = ~main_clk_buf;

  // Driver model
  logic hold_ack = 1'b0;
  int   wcnt, icnt;
  always @(posedge main_clk_buf or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      data_ack <= 1'b0;
      wcnt     <= 0;
      drv_idle <= 1'b1;
      icnt     <= 0;
    end else begin
      data_ack <= 1'b0;
      if (data_valid && !data_ack && !hold_ack) begin
        if (wcnt == 2) begin
          data_ack <= 1'b1;
          wcnt     <= 0;
        end else begin
          wcnt <= wcnt + 1;
        end
      end
      if (data_valid) begin
        drv_idle <= 1'b0;
        icnt     <= 0;
      end else if (!drv_idle) begin
        if (icnt == 4) drv_idle <= 1'b1;
        else           icnt     <= icnt + 1;
      end
    end
  end

  // Monitor: accepted words and busy rising edges
  int          cyc = 0;
  logic        busy_prev = 1'b0;
  logic [23:0] got_data[$];
  logic        got_last[$];
  int          rise_q[$];

  always @(posedge main_clk_buf) cyc <= cyc + 1;

  always @(negedge main_clk_buf) begin
    if (rst_sys_n && data_valid && data_ack) begin
      got_data.push_back(data);
      got_last.push_back(data_last);
    end
    if (busy && !busy_prev) rise_q.push_back(cyc);
    busy_prev <= busy;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // which: 0 busy, 1 data_valid, 2 drv_idle
  task automatic wait_sig(input int which, input logic val, input int limit, output bit ok);
    logic s;
    ok = 1'b0;
    for (int i = 0; i <= limit; i++) begin
      case (which)
        0:       s = busy;
        1:       s = data_valid;
        default: s = drv_idle;
      endcase
      if (s === val) begin
        ok = 1'b1;
        break;
      end
      @(negedge main_clk_buf);
    end
  endtask

  task automatic wait_words(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= limit; i++) begin
      if (got_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge main_clk_buf);
    end
  endtask

  task automatic clear_q();
    got_data.delete();
    got_last.delete();
  endtask

  task automatic pulse_update();
    update = 1'b1;
    @(negedge main_clk_buf);
    update = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [23:0] w0, input logic [23:0] w1);
    bit ok;
    wait_words(2, 300, ok);
    if (!ok) begin
      timeout_fail({name, "_words"});
    end else begin
      check({name, "_w0"}, 32'(got_data[0]), 32'(w0));
      check({name, "_last0"}, 32'(got_last[0]), 32'd0);
      check({name, "_w1"}, 32'(got_data[1]), 32'(w1));
      check({name, "_last1"}, 32'(got_last[1]), 32'd1);
    end
  endtask

  typedef struct {
    logic [47:0] leds;
    logic        off;
    logic [23:0] w0;
    logic [23:0] w1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit ok;
    int n;
    logic [23:0] d0;
    logic        l0;
    int          bad;

    vecs[0] = '{{24'h0000FF, 24'h112233}, 1'b0, 24'h221133, 24'h0000FF};
    vecs[1] = '{{24'hAABBCC, 24'h010203}, 1'b1, 24'h000000, 24'h000000};
    vecs[2] = '{{24'hFF0000, 24'h00FF00}, 1'b0, 24'hFF0000, 24'h00FF00};
    vecs[3] = '{{24'h123456, 24'hABCDEF}, 1'b0, 24'hCDABEF, 24'h341256};

    rst_sys_n = 1'b0;
    update    = 1'b0;
    off       = 1'b0;
    led_rgb   = {24'h0000FF, 24'h112233};
`ifdef RGBLED_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    repeat (3) @(negedge main_clk_buf);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_go", 32'(go), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_last", 32'(data_last), 32'd0);

    // First frame comes out of reset on its own.
    rst_sys_n = 1'b1;
    check_frame("first", 24'h221133, 24'h0000FF);
    wait_sig(2, 1'b1, 100, ok);
    if (!ok) timeout_fail("first_idle");
    n = 0;
    while (busy && n < 3000) begin
      @(negedge main_clk_buf);
      n++;
    end
    // Busy drops one cycle after the full latch gap, counted from idle rising.
    check("latch_gap", 32'(n), 32'(LatchCycles + 1));

    for (int i = 0; i < 4; i++) begin
      wait_sig(0, 1'b0, 3000, ok);
      if (!ok) timeout_fail($sformatf("vec%0d_idle", i));
      led_rgb = vecs[i].leds;
      off     = vecs[i].off;
      clear_q();
      pulse_update();
      check_frame($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1);
      off = 1'b0;
    end

    // Stalled handshake with colours changing under the frame.
    wait_sig(0, 1'b0, 3000, ok);
    if (!ok) timeout_fail("hold_idle");
    hold_ack = 1'b1;
    led_rgb  = {24'h0000FF, 24'h112233};
    clear_q();
    pulse_update();
    wait_sig(1, 1'b1, 50, ok);
    if (!ok) timeout_fail("hold_valid");
    d0  = data;
    l0  = data_last;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      led_rgb = {24'(i * 7 + 1), 24'(i * 13 + 5)};
      @(negedge main_clk_buf);
      if (data !== d0 || data_last !== l0 || data_valid !== 1'b1) bad++;
    end
    check("hold_stable_cycles_bad", 32'(bad), 32'd0);
    check("hold_word", 32'(d0), 32'h221133);
    hold_ack = 1'b0;
    check_frame("hold", 24'h221133, 24'h0000FF);

    // Three requests during the latch gap collapse into one follow-up frame.
    wait_sig(0, 1'b0, 3000, ok);
    if (!ok) timeout_fail("latchreq_idle");
    clear_q();
    pulse_update();
    wait_words(2, 300, ok);
    if (!ok) timeout_fail("latchreq_words");
    wait_sig(2, 1'b1, 100, ok);
    if (!ok) timeout_fail("latchreq_drv_idle");
    repeat (10) @(negedge main_clk_buf);
    for (int i = 0; i < 3; i++) begin
      pulse_update();
      repeat (4) @(negedge main_clk_buf);
    end
    check("latchreq_in_frame", 32'(busy), 32'd1);
    wait_sig(0, 1'b0, 3000, ok);
    if (!ok) timeout_fail("latchreq_end");
    n = 0;
    while (!busy && n < 3000) begin
      @(negedge main_clk_buf);
      n++;
    end
    check("latchreq_gap", 32'(n), 32'd1);
    wait_sig(0, 1'b0, 3000, ok);
    if (!ok) timeout_fail("latchreq_end2");
    n = 0;
    while (!busy && n < 3000) begin
      @(negedge main_clk_buf);
      n++;
    end
    check("no_extra_frame_idle_cycles", 32'(n), 32'(RefreshCycles));

    // Periodic refresh spacing.
    wait_sig(0, 1'b0, 3000, ok);
    if (!ok) timeout_fail("refresh_idle");
    rise_q.delete();
    for (int i = 0; i < 3 * (RefreshCycles + FrameCycles) + 100; i++) begin
      if (rise_q.size() >= 3) break;
      @(negedge main_clk_buf);
    end
    if (rise_q.size() < 3) begin
      timeout_fail("refresh_starts");
    end else begin
      check("refresh_gap1", 32'(rise_q[1] - rise_q[0]), 32'(RefreshCycles + FrameCycles));
      check("refresh_gap2", 32'(rise_q[2] - rise_q[1]), 32'(RefreshCycles + FrameCycles));
    end

    // Reset mid-word.
    wait_sig(0, 1'b0, 3000, ok);
    if (!ok) timeout_fail("rstmid_idle");
    led_rgb = {24'h0000FF, 24'h112233};
    pulse_update();
    wait_sig(1, 1'b1, 50, ok);
    if (!ok) timeout_fail("rstmid_valid");
    @(negedge main_clk_buf);
    #2 rst_sys_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_go", 32'(go), 32'd0);
    check("rstmid_data", 32'(data), 32'd0);
    check("rstmid_valid", 32'(data_valid), 32'd0);
    check("rstmid_last", 32'(data_last), 32'd0);
    @(negedge main_clk_buf);
    clear_q();
    rst_sys_n = 1'b1;
    check_frame("rstmid", 24'h221133, 24'h0000FF);

`ifdef RGBLED_BRIGHTNESS_EN
    wait_sig(0, 1'b0, 3000, ok);
    if (!ok) timeout_fail("bright_idle");
    brightness = 8'd127;
    led_rgb    = {24'h000000, 24'hFF0000};
    clear_q();
    pulse_update();
    check_frame("bright", 24'h007F00, 24'h000000);
    brightness = 8'd255;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
